// File: rtl/pix_pll_pkg.sv
// Shared types for the pixel PLL reconfiguration sequencer.
// Counter/parameter encodings follow the PLL reconfig port map.
package pix_pll_pkg;

    localparam logic [3:0] CT_N   = 4'd0;
    localparam logic [3:0] CT_M   = 4'd1;
    localparam logic [3:0] CT_C0  = 4'd4;

    localparam logic [2:0] CP_HI  = 3'd0;
    localparam logic [2:0] CP_LO  = 3'd1;
    localparam logic [2:0] CP_BYP = 3'd4;
    localparam logic [2:0] CP_ODD = 3'd5;

    typedef enum logic [1:0] {
        EC_NONE  = 2'd0,
        EC_RATIO = 2'd1,
        EC_BUSY  = 2'd2,
        EC_LOCK  = 2'd3
    } err_code_e;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CHK,
        S_WR,
        S_WR_WAIT,
        S_RC,
        S_RC_WAIT,
        S_LK,
        S_AR,
        S_ERR
    } state_e;

    typedef struct packed {
        logic [8:0] hi;
        logic [8:0] lo;
        logic [8:0] byp;
        logic [8:0] odd;
    } div_par_t;

endpackage

// File: rtl/pll_div_conv.sv
// Division ratio to PLL counter parameters (high, low, bypass, odd).
// A ratio of 1 is expressed as bypass with both half-counts at 1.
module pll_div_conv
    import pix_pll_pkg::*;
(
    input  logic [8:0] d_i,
    output div_par_t   par_o
);

    logic [9:0] sum;

    assign sum = {1'b0, d_i} + 10'd1;

    always_comb begin
        par_o.hi  = 9'(sum >> 1);
        par_o.lo  = (d_i == 9'd1) ? 9'd1 : {1'b0, d_i[8:1]};
        par_o.byp = {8'd0, d_i == 9'd1};
        par_o.odd = {8'd0, d_i[0]};
    end

endmodule

// File: rtl/pix_pll_seq.sv
// Pixel PLL reconfiguration sequencer: streams N/M/C0 counter parameters,
// triggers reconfig and supervises re-lock with one areset retry.
module pix_pll_seq
    import pix_pll_pkg::*;
#(
    parameter int unsigned BUSY_TMO = 1024,
    parameter int unsigned LOCK_TMO = 65536,
    parameter int unsigned ARST_CYC = 16
) (
    input  logic       hb_clk,
    input  logic       hb_rstn,
    input  logic       start,
    input  logic [8:0] n_div,
    input  logic [8:0] m_div,
    input  logic [8:0] c0_div,
    input  logic       pll_busy,
    input  logic       pix_locked,
    output logic       write_param,
    output logic       reconfig,
    output logic [3:0] counter_type,
    output logic [2:0] counter_param,
    output logic [8:0] data_in,
    output logic       pll_areset_in,
    output logic       seq_busy,
    output logic       done,
    output logic       err,
    output logic [1:0] err_code,
    output logic       locked_s
);

    localparam logic [16:0] BUSY_LIM  = 17'(BUSY_TMO);
    localparam logic [16:0] LOCK_LIM  = 17'(LOCK_TMO);
    localparam logic [16:0] ARST_LAST = 17'(ARST_CYC - 1);
    localparam logic [16:0] GUARD     = 17'd2;

    state_e     state_q, state_d;
    err_code_e  ec_q, ec_d;
    logic [3:0] step_q, step_d;
    logic [8:0] n_q, n_d, m_q, m_d, c0_q, c0_d;
    logic       retry_q, retry_d;
    logic       err_q, err_d;
    logic       done_q, done_d;
    logic [16:0] tmr_q, tmr_d;
    logic       sync1_q, sync2_q;
    logic [8:0] ratio;
    div_par_t   par;
    logic       busy_clr, busy_tmo;

    pll_div_conv u_conv (
        .d_i   (ratio),
        .par_o (par)
    );

    always_comb begin
        ratio        = n_q;
        counter_type = CT_N;
        unique case (step_q[3:2])
            2'd0: begin ratio = n_q;  counter_type = CT_N;  end
            2'd1: begin ratio = m_q;  counter_type = CT_M;  end
            default: begin ratio = c0_q; counter_type = CT_C0; end
        endcase
        counter_param = CP_HI;
        data_in       = par.hi;
        unique case (step_q[1:0])
            2'd0: begin counter_param = CP_HI;  data_in = par.hi;  end
            2'd1: begin counter_param = CP_LO;  data_in = par.lo;  end
            2'd2: begin counter_param = CP_BYP; data_in = par.byp; end
            default: begin counter_param = CP_ODD; data_in = par.odd; end
        endcase
    end

    // The first two wait cycles hide busy, which may lag the strobe.
    assign busy_clr = (tmr_q >= GUARD) && !pll_busy;
    assign busy_tmo = tmr_q >= BUSY_LIM;

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        n_d     = n_q;
        m_d     = m_q;
        c0_d    = c0_q;
        retry_d = retry_q;
        err_d   = err_q;
        ec_d    = ec_q;
        done_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    n_d     = n_div;
                    m_d     = m_div;
                    c0_d    = c0_div;
                    err_d   = 1'b0;
                    ec_d    = EC_NONE;
                    retry_d = 1'b0;
                    state_d = S_CHK;
                end
            end
            S_CHK: begin
                if (n_q == 9'd0 || m_q == 9'd0 || c0_q == 9'd0) begin
                    err_d   = 1'b1;
                    ec_d    = EC_RATIO;
                    state_d = S_IDLE;
                end else begin
                    step_d  = 4'd0;
                    state_d = S_WR;
                end
            end
            S_WR: state_d = S_WR_WAIT;
            S_WR_WAIT: begin
                if (busy_clr) begin
                    if (step_q == 4'd11) begin
                        state_d = S_RC;
                    end else begin
                        step_d  = step_q + 4'd1;
                        state_d = S_WR;
                    end
                end else if (busy_tmo) begin
                    err_d   = 1'b1;
                    ec_d    = EC_BUSY;
                    state_d = S_ERR;
                end
            end
            S_RC: state_d = S_RC_WAIT;
            S_RC_WAIT: begin
                if (busy_clr) begin
                    state_d = S_LK;
                end else if (busy_tmo) begin
                    err_d   = 1'b1;
                    ec_d    = EC_BUSY;
                    state_d = S_ERR;
                end
            end
            S_LK: begin
                if (sync2_q) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (tmr_q >= LOCK_LIM) begin
                    if (retry_q) begin
                        err_d   = 1'b1;
                        ec_d    = EC_LOCK;
                        state_d = S_ERR;
                    end else begin
                        retry_d = 1'b1;
                        state_d = S_AR;
                    end
                end
            end
            S_AR: if (tmr_q >= ARST_LAST) state_d = S_LK;
            S_ERR: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Timer restarts on every state change and saturates instead of wrapping.
    always_comb begin
        if (state_d != state_q) tmr_d = '0;
        else if (&tmr_q)        tmr_d = tmr_q;
        else                    tmr_d = tmr_q + 17'd1;
    end

    always_ff @(posedge hb_clk) begin
        if (!hb_rstn) begin
            state_q <= S_IDLE;
            ec_q    <= EC_NONE;
            step_q  <= '0;
            n_q     <= '0;
            m_q     <= '0;
            c0_q    <= '0;
            retry_q <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            tmr_q   <= '0;
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ec_q    <= ec_d;
            step_q  <= step_d;
            n_q     <= n_d;
            m_q     <= m_d;
            c0_q    <= c0_d;
            retry_q <= retry_d;
            err_q   <= err_d;
            done_q  <= done_d;
            tmr_q   <= tmr_d;
            sync1_q <= pix_locked;
            sync2_q <= sync1_q;
        end
    end

    assign write_param   = (state_q == S_WR);
    assign reconfig      = (state_q == S_RC);
    assign pll_areset_in = (state_q == S_AR);
    assign seq_busy      = (state_q != S_IDLE);
    assign done          = done_q;
    assign err           = err_q;
    assign err_code      = ec_q;
    assign locked_s      = sync2_q;

endmodule
